// File: rtl/euler_update_pipe.sv
// rtl/euler_update_pipe.sv - Euler-step writeback pipeline: add, fixed-point scale, write to state RAM
//
// Purpose:
//   For each of NUM_VARS state variables in a step, accepts an operand pair,
//   adds it, multiplies the sum by the latched step size h in signed fixed
//   point (FRAC_BITS fractional bits), and writes the result to
//   base_addr+1+index. The multiply is a DATA_SIZE-cycle shift-add unit, so
//   its latency does not depend on the operand values.
//
// Configuration macro:
//   EULER_SAT_EN - when defined, add and product overflow saturate to the
//                  most positive / most negative value instead of wrapping.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               arm a step (IDLE only); latches base_addr and h_step
//   base_addr, h_step   step base address and step size
//   in_valid, in_a,
//   in_b, in_ready      operand pair handshake
//   wr_en, wr_addr,
//   wr_data             state RAM write port
//   step_done           pulse with the last write of a step
//   busy                high outside IDLE
//   carry_out, negative flags of the last addition
//   overflow            sticky overflow for the current step
module euler_update_pipe #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_VARS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic [DATA_SIZE-1:0] h_step,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_a,
  input  logic [DATA_SIZE-1:0] in_b,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADD_SIZE-1:0]  wr_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 step_done,
  output logic                 busy,
  output logic                 carry_out,
  output logic                 negative,
  output logic                 overflow
);

  localparam int N     = DATA_SIZE;
  localparam int W     = 2 * DATA_SIZE;
  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE - 1);
  localparam logic [N-1:0]     MAX_V    = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     MIN_V    = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]          state;
  logic [ADD_SIZE-1:0] base_q;
  logic [N-1:0]        h_q;
  logic [IDX_W-1:0]    idx;
  logic [N-1:0]        a_q, b_q;
  logic [W-1:0]        acc, mcand;
  logic [N-1:0]        mplier;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt;

  logic [N:0]          sum_full;
  logic [N-1:0]        sum_w, sum_fin, mag_s, mag_h, result;
  logic                add_ovf, prod_fits;
  logic [W-1:0]        acc_nxt;
  logic signed [W-1:0] prod_s, shifted;
  logic [N:0]          top;

  assign in_ready = (state == S_READY);
  assign busy     = (state != S_IDLE);

  always_comb begin
    sum_full = {1'b0, a_q} + {1'b0, b_q};
    sum_w    = sum_full[N-1:0];
    add_ovf  = (a_q[N-1] == b_q[N-1]) && (sum_w[N-1] != a_q[N-1]);
`ifdef EULER_SAT_EN
    sum_fin  = add_ovf ? (a_q[N-1] ? MIN_V : MAX_V) : sum_w;
`else
    sum_fin  = sum_w;
`endif
    // Multiply magnitudes unsigned and restore the sign at the end; the
    // magnitude of the most negative value still fits in N unsigned bits.
    mag_s    = sum_fin[N-1] ? (~sum_fin + N'(1)) : sum_fin;
    mag_h    = h_q[N-1] ? (~h_q + N'(1)) : h_q;
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
    prod_s   = neg_q ? -acc_nxt : acc_nxt;
    shifted  = prod_s >>> FRAC_BITS;
    // Representable in N signed bits iff the top N+1 bits are all equal.
    top       = shifted[W-1:N-1];
    prod_fits = (&top) | ~(|top);
`ifdef EULER_SAT_EN
    result   = prod_fits ? shifted[N-1:0] : (shifted[W-1] ? MIN_V : MAX_V);
`else
    result   = shifted[N-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      h_q       <= '0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      step_done <= 1'b0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      step_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            h_q      <= h_step;
            idx      <= '0;
            overflow <= 1'b0;
            state    <= S_READY;
          end
        end
        S_READY: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          carry_out <= sum_full[N];
          negative  <= sum_w[N-1];
          if (add_ovf) overflow <= 1'b1;
          acc    <= '0;
          mcand  <= {{N{1'b0}}, mag_s};
          mplier <= mag_h;
          neg_q  <= sum_fin[N-1] ^ h_q[N-1];
          cnt    <= '0;
          state  <= S_MUL;
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            wr_en     <= 1'b1;
            wr_addr   <= base_q + ADD_SIZE'(1) + ADD_SIZE'(idx);
            wr_data   <= result;
            step_done <= (idx == LAST_IDX);
            if (!prod_fits) overflow <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx == LAST_IDX) begin
            state <= S_IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
